// File: rtl/act_window_feeder.sv
// Activation window feeder: collects a window of activation columns from a
// valid/ready stream, then presents the whole window on dout for k or 2*k
// cycles (depending on stride) before refilling for the next window.
module act_window_feeder #(
  parameter int Ram_Row    = 33,
  parameter int Data_Width = 64,
  parameter int Pe_Mac     = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    kernel_size,
  input  logic [1:0]                    stride,
  input  logic [7:0]                    num_windows,
  input  logic                          start,
  input  logic [Data_Width-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [Data_Width*Ram_Row-1:0] dout,
  output logic                          tready,
  output logic                          reset,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t                r_state;
  state_t                w_next;

  logic [2:0]            r_k;
  logic [1:0]            r_stride;
  logic [7:0]            r_num_win;
  logic [5:0]            r_fill_cnt;
  logic [7:0]            r_win_cnt;
  logic [4:0]            r_hold_cnt;
  logic [Data_Width-1:0] r_ent [Ram_Row];
  logic                  r_done;
  logic                  r_err;

  logic                  w_cfg_ok;
  logic [5:0]            w_need;
  logic [4:0]            w_hold_len;
  logic                  w_hold_last;
  logic                  w_half_end;
  logic                  w_more;
  logic                  w_start_ok;
  logic                  w_start_bad;

  // Number of columns a window needs: stride 1 covers 2*Pe_Mac-1 positions
  // plus the kernel, stride 2 skips every other column.
  function automatic logic [5:0] calc_need(input logic [2:0] k, input logic [1:0] s);
    logic [5:0] base;
    if (s == 2'd1) base = 6'(2 * Pe_Mac - 1);
    else           base = 6'((Pe_Mac - 1) * 2);
    return base + {3'b000, k};
  endfunction

  assign w_cfg_ok = (calc_need(kernel_size, stride) <= 6'(Ram_Row)) &&
                    (kernel_size != 3'd0) &&
                    ((stride == 2'd1) || (stride == 2'd2)) &&
                    (num_windows != 8'd0);

  assign w_need      = calc_need(r_k, r_stride);
  assign w_hold_len  = (r_stride == 2'd1) ? {1'b0, r_k, 1'b0} : {2'b00, r_k};
  assign w_hold_last = (r_hold_cnt == (w_hold_len - 5'd1));
  // Stride 1 splits HOLD into two halves of k cycles; mark the last of each.
  assign w_half_end  = (r_stride == 2'd1) &&
                       ((r_hold_cnt == ({2'b00, r_k} - 5'd1)) || w_hold_last);
  assign w_more      = (({1'b0, r_win_cnt} + 9'd1) < {1'b0, r_num_win});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next      = r_state;
    s_ready     = 1'b0;
    tready      = 1'b0;
    reset       = 1'b0;
    busy        = 1'b0;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_cfg_ok) begin
            w_next     = FILL;
            w_start_ok = 1'b1;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      FILL: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid && ((r_fill_cnt + 6'd1) == w_need)) w_next = HOLD;
      end
      HOLD: begin
        busy   = 1'b1;
        tready = 1'b1;
        reset  = w_half_end;
        if (w_hold_last) w_next = w_more ? FILL : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Job configuration, counters, window storage and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k        <= '0;
      r_stride   <= '0;
      r_num_win  <= '0;
      r_fill_cnt <= '0;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < Ram_Row; i++) r_ent[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_k        <= kernel_size;
        r_stride   <= stride;
        r_num_win  <= num_windows;
        r_fill_cnt <= '0;
        r_win_cnt  <= '0;
        r_hold_cnt <= '0;
        r_err      <= 1'b0;
        for (int i = 0; i < Ram_Row; i++) r_ent[i] <= '0;
      end else if (w_start_bad) begin
        r_err <= 1'b1;
      end
      if ((r_state == FILL) && s_valid) begin
        r_ent[r_fill_cnt] <= s_data;
        r_fill_cnt        <= r_fill_cnt + 6'd1;
        r_hold_cnt        <= '0;
      end
      if (r_state == HOLD) begin
        if (w_hold_last) begin
          r_win_cnt  <= r_win_cnt + 8'd1;
          r_hold_cnt <= '0;
          if (w_more) begin
            r_fill_cnt <= '0;
            for (int i = 0; i < Ram_Row; i++) r_ent[i] <= '0;
          end else begin
            r_done <= 1'b1;
          end
        end else begin
          r_hold_cnt <= r_hold_cnt + 5'd1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < Ram_Row; gi++) begin : g_dout
      assign dout[gi*Data_Width +: Data_Width] = r_ent[gi];
    end
  endgenerate

  assign done = r_done;
  assign err  = r_err;

endmodule
